// File: rtl/util_cpack2_timestamp_check_if.sv
// Packed-word write stream between the timestamp inserter, this checker and the DMA write FIFO.
// Master drives the word; slave reports overflow back.
interface util_cpack2_timestamp_check_if #(
  parameter int unsigned DW = 64
);
  logic          wr_en;
  logic          wr_sync;
  logic [DW-1:0] wr_data;
  logic          wr_overflow;

  modport master (
    output wr_en,
    output wr_sync,
    output wr_data,
    input  wr_overflow
  );

  modport slave (
    input  wr_en,
    input  wr_sync,
    input  wr_data,
    output wr_overflow
  );
endinterface

// File: rtl/util_cpack2_timestamp_check.sv
// Timestamp framing checker: forwards the stream with one cycle latency and verifies timestamps.
// Optional UTIL_CPACK2_TIMESTAMP_CHECK_STRIP_EN removes timestamp words from the output stream.
module util_cpack2_timestamp_check #(
  parameter int unsigned NUM_OF_CHANNELS     = 4,
  parameter int unsigned SAMPLES_PER_CHANNEL = 1,
  parameter int unsigned SAMPLE_DATA_WIDTH   = 16
) (
  input  logic                                dma_clk,
  input  logic                                dma_resetn,
  input  logic [31:0]                         timestamp_every,
  input  logic [63:0]                         timestamp_increment,
  input  logic                                error_clear,
  util_cpack2_timestamp_check_if.slave        in_wr,
  util_cpack2_timestamp_check_if.master       out_wr,
  output logic                                ts_locked,
  output logic [63:0]                         ts_last,
  output logic                                ts_error_pulse,
  output logic [31:0]                         ts_error_count
);

  // The timestamp occupies the low 64 bits, so the packed word must be at least that wide.
  localparam int unsigned DW = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;

  typedef enum logic [1:0] {StBypass, StHunt, StData, StTs} state_e;

  state_e          state_q, state_d;
  logic [31:0]     frame_len_q, frame_len_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [63:0]     ts_last_q, ts_last_d;
  logic [31:0]     err_cnt_q, err_cnt_d;
  logic            err_pulse_q;
  logic            locked_q, locked_d;
  logic            out_en_q, out_sync_q;
  logic [DW-1:0]   out_data_q;

  logic            bypass;
  logic            ts_word;
  logic            err;
  logic            strip;
  logic            fwd;
  logic            fwd_sync;
  logic [63:0]     in_ts;
  logic [63:0]     ts_expect;

  assign in_wr.wr_overflow = out_wr.wr_overflow;

  assign bypass    = (timestamp_every == 32'd0);
  assign in_ts     = in_wr.wr_data[63:0];
  assign ts_expect = ts_last_q + timestamp_increment;

  // Framing FSM; ts_word marks the current input word as a timestamp to be latched.
  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    cnt_d       = cnt_q;
    ts_last_d   = ts_last_q;
    ts_word     = 1'b0;
    err         = 1'b0;
    if (bypass) begin
      state_d = StBypass;
    end else begin
      unique case (state_q)
        StBypass: state_d = StHunt;
        StHunt: begin
          if (in_wr.wr_en && in_wr.wr_sync) begin
            ts_word = 1'b1;
            state_d = StData;
          end
        end
        StData: begin
          if (in_wr.wr_en) begin
            if (in_wr.wr_sync) begin
              // Early timestamp: framing error, resynchronise on this word without comparing.
              ts_word = 1'b1;
              err     = 1'b1;
            end else begin
              cnt_d = cnt_q + 32'd1;
              if (cnt_d == frame_len_q) begin
                state_d = StTs;
              end
            end
          end
        end
        StTs: begin
          if (in_wr.wr_en) begin
            ts_word = 1'b1;
            err     = (in_ts != ts_expect);
            state_d = StData;
          end
        end
        default: state_d = StHunt;
      endcase
    end
    if (ts_word) begin
      ts_last_d   = in_ts;
      frame_len_d = timestamp_every;
      cnt_d       = 32'd0;
    end
  end

  assign locked_d = (state_d == StData) || (state_d == StTs);

  // Saturating error counter; a coincident clear still records the new error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (error_clear) begin
      err_cnt_d = {31'd0, err};
    end else if (err && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

`ifdef UTIL_CPACK2_TIMESTAMP_CHECK_STRIP_EN
  logic pend_sync_q, pend_sync_d;

  // A stripped timestamp hands its sync flag to the next forwarded word.
  always_comb begin
    strip       = ts_word;
    fwd_sync    = in_wr.wr_sync | pend_sync_q;
    pend_sync_d = pend_sync_q;
    if (ts_word) begin
      pend_sync_d = 1'b1;
    end else if (in_wr.wr_en) begin
      pend_sync_d = 1'b0;
    end
  end

  always_ff @(posedge dma_clk or negedge dma_resetn) begin
    if (!dma_resetn) begin
      pend_sync_q <= 1'b0;
    end else begin
      pend_sync_q <= pend_sync_d;
    end
  end
`else
  always_comb begin
    strip    = 1'b0;
    fwd_sync = in_wr.wr_sync;
  end
`endif

  assign fwd = in_wr.wr_en & ~strip;

  always_ff @(posedge dma_clk or negedge dma_resetn) begin
    if (!dma_resetn) begin
      state_q     <= StHunt;
      frame_len_q <= 32'd0;
      cnt_q       <= 32'd0;
      ts_last_q   <= 64'd0;
      err_cnt_q   <= 32'd0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      out_en_q    <= 1'b0;
      out_sync_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      cnt_q       <= cnt_d;
      ts_last_q   <= ts_last_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err;
      locked_q    <= locked_d;
      out_en_q    <= fwd;
      out_sync_q  <= fwd & fwd_sync;
      out_data_q  <= fwd ? in_wr.wr_data : '0;
    end
  end

  assign out_wr.wr_en   = out_en_q;
  assign out_wr.wr_sync = out_sync_q;
  assign out_wr.wr_data = out_data_q;
  assign ts_locked      = locked_q;
  assign ts_last        = ts_last_q;
  assign ts_error_pulse = err_pulse_q;
  assign ts_error_count = err_cnt_q;

endmodule

// File: doc/util_cpack2_timestamp_check.md
# util_cpack2_timestamp_check

Stream checker that sits directly downstream of the timestamp inserter on the ADC capture path, in the DMA clock domain, in front of the DMA write FIFO interface. It forwards the packed, timestamped word stream with one cycle of latency. It locks onto the frame structure (one timestamp word followed by `timestamp_every` data words) and verifies that each timestamp equals the previous one plus a programmed increment. Discontinuities, such as dropped samples upstream, are counted and reported.

## Interface
Parameters:
- `NUM_OF_CHANNELS`, 4, channel count.
- `SAMPLES_PER_CHANNEL`, 1, samples per channel per word.
- `SAMPLE_DATA_WIDTH`, 16, bits per sample.
- DW = `NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH`; DW ≥ 64 is required.

Ports:
- `dma_clk` in 1: single clock.
- `dma_resetn` in 1: asynchronous active-low reset.
- `timestamp_every` in 32: data words per frame; 0 = timestamping off (bypass).
- `timestamp_increment` in 64: expected difference between consecutive timestamps.
- `error_clear` in 1: synchronous clear of the error counter.
- `in_wr_en` in 1: input word valid.
- `in_wr_overflow` out 1: overflow reported upstream.
- `in_wr_sync` in 1: input sync; marks a timestamp word when timestamping is on.
- `in_wr_data` in DW: input word.
- `out_wr_en` out 1: output word valid.
- `out_wr_overflow` in 1: downstream overflow.
- `out_wr_sync` out 1: output sync.
- `out_wr_data` out DW: output word.
- `ts_locked` out 1: frame structure is locked.
- `ts_last` out 64: last received timestamp.
- `ts_error_pulse` out 1: one-cycle strobe per detected error.
- `ts_error_count` out 32: saturating error count.

## Operation
- State machine states: BYPASS, HUNT, DATA, TS. After reset the state is HUNT.
- If `timestamp_every`==0 in any state, go to BYPASS. Leave BYPASS for HUNT when `timestamp_every`≠0.
- HUNT: on `in_wr_en`&&`in_wr_sync`, the word is a timestamp.
  - `ts_last`←`in_wr_data[63:0]`.
  - `frame_len`←`timestamp_every`, `cnt`←0, `ts_locked`←1, go to DATA.
  - Words without sync are ignored for checking.
- DATA: each `in_wr_en` with sync=0 increments `cnt`. The word making `cnt`==`frame_len` moves the state to TS.
- DATA with `in_wr_en`&&`in_wr_sync` (early timestamp) is a framing error:
  - Count one error.
  - Treat the word as a timestamp: load `ts_last`, reload `frame_len`, `cnt`←0, stay in DATA.
  - Skip the increment comparison.
- TS: the next `in_wr_en` word is a timestamp regardless of sync.
  - Compare it with `ts_last`+`timestamp_increment` (64-bit, modulo 2^64).
  - Mismatch counts one error.
  - Always: `ts_last`←received value, `frame_len`←`timestamp_every`, `cnt`←0, go to DATA.
- `frame_len` is sampled only at timestamp words, so `timestamp_every` changes mid-frame take effect at the next frame.
- Error handling:
  - `ts_error_count` saturates at 0xFFFFFFFF.
  - `error_clear` sets it to 0. If an error occurs in the same cycle, it becomes 1.
- `ts_locked` clears in BYPASS and HUNT.
- `in_wr_overflow` = `out_wr_overflow`, combinational.

## Timing
- Reset values: `out_wr_en`=0, `out_wr_sync`=0, `out_wr_data`=0, `ts_locked`=0, `ts_last`=0, `ts_error_pulse`=0, `ts_error_count`=0.
- Data path: registered, 1-cycle latency. `out_wr_en`(t+1)=`in_wr_en`(t), and sync/data follow likewise. When `in_wr_en`=0, outputs drive 0.
- `ts_error_pulse`, `ts_last` and `ts_error_count` update on the cycle after the offending word, aligned with that word appearing on the output.
- No backpressure: every cycle may carry a word. Back-to-back timestamp words are legal and each one is checked.
- Reset asserted mid-frame: immediate return to reset values. Re-lock requires a fresh sync word.

## Configuration
- `UTIL_CPACK2_TIMESTAMP_CHECK_STRIP_EN`
- Defined: timestamp words (HUNT lock word, TS word, early-sync word) are not forwarded; `out_wr_en` stays 0 that cycle. The sync flag is carried over to the next forwarded data word. Checking is unchanged. In BYPASS, everything is forwarded.
- Undefined: all words are forwarded verbatim, including timestamp words with their sync bit.

## Test plan
- `timestamp_every`=4, increment=4, timestamps 100, 104, 108 each followed by 4 data words -> `ts_locked`=1 after first timestamp, 0 errors, `ts_last`=108, output equals input delayed by 1 cycle.
- Same stream but the second timestamp is 105 -> one `ts_error_pulse`, `ts_error_count`=1, `ts_last`=105; next timestamp 109 -> no error.
- Sync-flagged word arrives after 2 of 4 data words -> count 1, frame restarts, the following frame of 4 words is checked against that word's value.
- `timestamp_every`=0 with arbitrary traffic -> BYPASS, `ts_locked`=0, pass-through; switch to 4 mid-stream -> HUNT until the next sync word.
- Error count preset near saturation (0xFFFFFFFF) plus error -> stays at 0xFFFFFFFF; `error_clear` coincident with error -> 1; `dma_resetn` low mid-frame -> all outputs 0 on reset.
- With `UTIL_CPACK2_TIMESTAMP_CHECK_STRIP_EN`: a 1+4 word frame yields 4 output words, the first carrying `out_wr_sync`=1.
